vscale_dmem_bridge: RTL and testbench

Adapts the core's pipelined data-memory port to a valid/ready request/response memory bus. The core side has an address phase in DX and a data phase in WB, with store data arriving one cycle after the address. The bridge registers the access, generates byte strobes, and holds the core with dmem_wait until the bus responds. It reports misaligned, erroring and timed-out accesses on dmem_badmem_e. It sits between vscale_core and the data SRAM/interconnect.

---
 rtl/vscale_dmem_bridge.sv | 169 ++++++++++++++++
 tb/tb_vscale_dmem_bridge.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_dmem_bridge.sv
// Bridges the core's pipelined DX/WB data-memory port onto a valid/ready request/response bus.
// It also raises dmem_badmem_e for misaligned, bus-error and timed-out accesses.
module vscale_dmem_bridge #(
    parameter int unsigned  TIMEOUT_CYCLES = 255,
    localparam int unsigned XPR_LEN        = 32,
    localparam int unsigned MEM_TYPE_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dmem_en,
    input  logic                      dmem_wen,
    input  logic [MEM_TYPE_WIDTH-1:0] dmem_size,
    input  logic [XPR_LEN-1:0]        dmem_addr,
    input  logic [XPR_LEN-1:0]        dmem_wdata_delayed,
    output logic [XPR_LEN-1:0]        dmem_rdata,
    output logic                      dmem_wait,
    output logic                      dmem_badmem_e,
    output logic                      bus_req_valid,
    input  logic                      bus_req_ready,
    output logic                      bus_req_wen,
    output logic [XPR_LEN-1:0]        bus_req_addr,
    output logic [XPR_LEN-1:0]        bus_req_wdata,
    output logic [3:0]                bus_req_strb,
    input  logic                      bus_resp_valid,
    input  logic [XPR_LEN-1:0]        bus_resp_rdata,
    input  logic                      bus_resp_err
);

    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LH  = MEM_TYPE_WIDTH'(1);
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LW  = MEM_TYPE_WIDTH'(2);
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LD  = MEM_TYPE_WIDTH'(3);
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LHU = MEM_TYPE_WIDTH'(5);
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LWU = MEM_TYPE_WIDTH'(6);

    localparam int unsigned CNT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic        TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RESP  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [XPR_LEN-1:0] addr_q, addr_d;
    logic               wen_q, wen_d;
    logic               half_q, half_d;
    logic               word_q, word_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               in_half;
    logic               in_word;
    logic               in_misaligned;
    logic               timeout_hit;
    logic               accept;
    logic [3:0]         strb;

    // Access-size class and alignment of the address-phase request
    always_comb begin
        in_half       = (dmem_size == MEM_TYPE_LH) || (dmem_size == MEM_TYPE_LHU);
        in_word       = (dmem_size == MEM_TYPE_LW) || (dmem_size == MEM_TYPE_LWU) ||
                        (dmem_size == MEM_TYPE_LD);
        in_misaligned = (in_half && dmem_addr[0]) || (in_word && (dmem_addr[1:0] != 2'b00));
    end

    always_comb begin
        if (word_q) begin
            strb = 4'b1111;
        end else if (half_q) begin
            strb = 4'b0011 << {addr_q[1], 1'b0};
        end else begin
            strb = 4'b0001 << addr_q[1:0];
        end
    end

    // Next state and outputs; a completing cycle doubles as an IDLE capture point
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        half_d        = half_q;
        word_d        = word_q;
        cnt_d         = cnt_q;
        accept        = 1'b0;
        dmem_rdata    = '0;
        dmem_wait     = 1'b0;
        dmem_badmem_e = 1'b0;
        bus_req_valid = 1'b0;
        timeout_hit   = TIMEOUT_EN && (cnt_q == CNT_LAST);

        case (state_q)
            ST_IDLE: begin
                accept = 1'b1;
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (timeout_hit) begin
                    dmem_badmem_e = 1'b1;
                    accept        = 1'b1;
                end else begin
                    bus_req_valid = 1'b1;
                    dmem_wait     = 1'b1;
                    if (bus_req_ready) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_resp_valid) begin
                    dmem_rdata    = bus_resp_rdata;
                    dmem_badmem_e = bus_resp_err;
                    accept        = 1'b1;
                end else if (timeout_hit) begin
                    dmem_badmem_e = 1'b1;
                    accept        = 1'b1;
                end else begin
                    dmem_wait = 1'b1;
                end
            end
            ST_FAULT: begin
                dmem_badmem_e = 1'b1;
                accept        = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            if (dmem_en) begin
                addr_d  = dmem_addr;
                wen_d   = dmem_wen;
                half_d  = in_half;
                word_d  = in_word;
                cnt_d   = '0;
                state_d = in_misaligned ? ST_FAULT : ST_REQ;
            end else begin
                state_d = ST_IDLE;
            end
        end

        bus_req_wen   = bus_req_valid && wen_q;
        bus_req_addr  = bus_req_valid ? {addr_q[XPR_LEN-1:2], 2'b00} : '0;
        bus_req_wdata = bus_req_valid ? dmem_wdata_delayed : '0;
        bus_req_strb  = (bus_req_valid && wen_q) ? strb : 4'b0000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            half_q  <= 1'b0;
            word_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            half_q  <= half_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// Directed bench for vscale_dmem_bridge: a vector table with a small bus responder,
// plus hand-written back-to-back, timeout and mid-access reset sequences.
module tb_vscale_dmem_bridge;

    logic        clk;
    logic        reset;
    logic        dmem_en;
    logic        dmem_wen;
    logic [2:0]  dmem_size;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata_delayed;
    logic        bus_req_ready;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_rdata;
    logic        bus_resp_err;

    logic [31:0] dmem_rdata,    to_dmem_rdata;
    logic        dmem_wait,     to_dmem_wait;
    logic        dmem_badmem_e, to_dmem_badmem_e;
    logic        bus_req_valid, to_bus_req_valid;
    logic        bus_req_wen,   to_bus_req_wen;
    logic [31:0] bus_req_addr,  to_bus_req_addr;
    logic [31:0] bus_req_wdata, to_bus_req_wdata;
    logic [3:0]  bus_req_strb,  to_bus_req_strb;

    int n_tests = 0;
    int n_fail  = 0;

    vscale_dmem_bridge dut (
        .clk(clk), .reset(reset), .dmem_en(dmem_en), .dmem_wen(dmem_wen),
        .dmem_size(dmem_size), .dmem_addr(dmem_addr), .dmem_wdata_delayed(dmem_wdata_delayed),
        .dmem_rdata(dmem_rdata), .dmem_wait(dmem_wait), .dmem_badmem_e(dmem_badmem_e),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_wen(bus_req_wen),
        .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_strb(bus_req_strb),
        .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata), .bus_resp_err(bus_resp_err)
    );

    vscale_dmem_bridge #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .reset(reset), .dmem_en(dmem_en), .dmem_wen(dmem_wen),
        .dmem_size(dmem_size), .dmem_addr(dmem_addr), .dmem_wdata_delayed(dmem_wdata_delayed),
        .dmem_rdata(to_dmem_rdata), .dmem_wait(to_dmem_wait), .dmem_badmem_e(to_dmem_badmem_e),
        .bus_req_valid(to_bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_wen(to_bus_req_wen),
        .bus_req_addr(to_bus_req_addr), .bus_req_wdata(to_bus_req_wdata), .bus_req_strb(to_bus_req_strb),
        .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata), .bus_resp_err(bus_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rdy_dly;
        int          resp_dly;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        logic        exp_req;
        logic        exp_bad;
        int          exp_wait;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];
    int   cur;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d %s: got %h expected %h", cur, nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        dmem_en        = 1'b0;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        bus_resp_err   = 1'b0;
        bus_resp_rdata = '0;
    endtask

    // One access against a responder that holds ready low rdy_dly cycles and
    // answers resp_dly cycles after the handshake
    task automatic run_vec(input vec_t v);
        bit acc, saw_req, done;
        int req_cnt, resp_cnt, waits;
        @(negedge clk);
        idle_inputs();
        dmem_en   = 1'b1;
        dmem_wen  = v.wen;
        dmem_size = v.size;
        dmem_addr = v.addr;
        #1;
        chk("idle_wait", 32'(dmem_wait), 32'd0);
        acc = 0; saw_req = 0; done = 0;
        req_cnt = 0; resp_cnt = 0; waits = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            dmem_en            = 1'b0;
            dmem_wdata_delayed = v.wdata;
            if (!acc) begin
                bus_req_ready  = (req_cnt >= v.rdy_dly);
                bus_resp_valid = 1'b0;
            end else begin
                bus_req_ready  = 1'b0;
                bus_resp_valid = (resp_cnt == v.resp_dly);
                bus_resp_rdata = v.rdata;
                bus_resp_err   = v.err;
            end
            #1;
            if (bus_req_valid && !saw_req) begin
                saw_req = 1;
                chk("req_addr",  bus_req_addr, v.exp_addr);
                chk("req_strb",  32'(bus_req_strb), 32'(v.exp_strb));
                chk("req_wdata", bus_req_wdata, v.wdata);
                chk("req_wen",   32'(bus_req_wen), 32'(v.wen));
            end
            if (!dmem_wait) begin
                done = 1;
                chk("badmem", 32'(dmem_badmem_e), 32'(v.exp_bad));
                chk("rdata", dmem_rdata, v.exp_rdata);
                chk("done_valid", 32'(bus_req_valid), 32'd0);
            end else begin
                waits++;
            end
            if (!acc) begin
                if (bus_req_valid && bus_req_ready) acc = 1;
                else req_cnt++;
            end else begin
                resp_cnt++;
            end
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL v%0d completion: no completion within 40 cycles", cur);
        end
        chk("wait_cycles", 32'(waits), 32'(v.exp_wait));
        chk("saw_req", 32'(saw_req), 32'(v.exp_req));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int waits;
        bit done;
        //          wen   sz    addr       wdata        rdy resp rdata        err  exp_addr   strb    req   bad  wait exp_rdata
        vecs[0]  = '{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0,        1'b0, 32'h100, 4'b1111, 1'b1, 1'b0, 2, 32'h0};
        vecs[1]  = '{1'b1, 3'd0, 32'h103, 32'h44444444, 0, 1, 32'h0,        1'b0, 32'h100, 4'b1000, 1'b1, 1'b0, 2, 32'h0};
        vecs[2]  = '{1'b1, 3'd1, 32'h102, 32'h55555555, 0, 1, 32'h0,        1'b0, 32'h100, 4'b1100, 1'b1, 1'b0, 2, 32'h0};
        vecs[3]  = '{1'b0, 3'd2, 32'h204, 32'h0,        3, 2, 32'h12345678, 1'b0, 32'h204, 4'b0000, 1'b1, 1'b0, 6, 32'h12345678};
        vecs[4]  = '{1'b0, 3'd1, 32'h101, 32'h0,        0, 1, 32'h0,        1'b0, 32'h0,   4'b0000, 1'b0, 1'b1, 0, 32'h0};
        vecs[5]  = '{1'b1, 3'd2, 32'h102, 32'h11111111, 0, 1, 32'h0,        1'b0, 32'h0,   4'b0000, 1'b0, 1'b1, 0, 32'h0};
        vecs[6]  = '{1'b0, 3'd2, 32'h300, 32'h0,        0, 1, 32'hCAFEF00D, 1'b1, 32'h300, 4'b0000, 1'b1, 1'b1, 2, 32'hCAFEF00D};
        vecs[7]  = '{1'b1, 3'd0, 32'h101, 32'hAAAAAAAA, 1, 0, 32'h0,        1'b0, 32'h100, 4'b0010, 1'b1, 1'b0, 2, 32'h0};
        vecs[8]  = '{1'b1, 3'd1, 32'h100, 32'h66666666, 0, 3, 32'h0,        1'b0, 32'h100, 4'b0011, 1'b1, 1'b0, 4, 32'h0};
        vecs[9]  = '{1'b0, 3'd4, 32'h007, 32'h0,        0, 1, 32'h0BADF00D, 1'b0, 32'h004, 4'b0000, 1'b1, 1'b0, 2, 32'h0BADF00D};
        vecs[10] = '{1'b0, 3'd5, 32'h00B, 32'h0,        0, 1, 32'h0,        1'b0, 32'h0,   4'b0000, 1'b0, 1'b1, 0, 32'h0};
        vecs[11] = '{1'b1, 3'd0, 32'h102, 32'h77777777, 0, 1, 32'h0,        1'b0, 32'h100, 4'b0100, 1'b1, 1'b0, 2, 32'h0};

        cur = -1;
        reset = 1'b1;
        idle_inputs();
        dmem_wen = 0; dmem_size = 0; dmem_addr = 0; dmem_wdata_delayed = 0;
        #2;
        chk("rst_wait",   32'(dmem_wait), 32'd0);
        chk("rst_badmem", 32'(dmem_badmem_e), 32'd0);
        chk("rst_valid",  32'(bus_req_valid), 32'd0);
        chk("rst_addr",   bus_req_addr, 32'd0);
        chk("rst_rdata",  dmem_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            cur = i;
            run_vec(vecs[i]);
        end

        // Back-to-back: new access presented in a response-completion cycle
        cur = 100;
        @(negedge clk);
        idle_inputs();
        dmem_en = 1; dmem_wen = 1; dmem_size = 3'd2; dmem_addr = 32'h400;
        @(negedge clk);
        dmem_en = 0; bus_req_ready = 1; dmem_wdata_delayed = 32'h11111111;
        #1;
        chk("b2b_req1_valid", 32'(bus_req_valid), 32'd1);
        chk("b2b_req1_addr", bus_req_addr, 32'h400);
        @(negedge clk);
        bus_req_ready = 0;
        #1;
        chk("b2b_resp1_wait", 32'(dmem_wait), 32'd1);
        chk("b2b_resp1_valid", 32'(bus_req_valid), 32'd0);
        @(negedge clk);
        bus_resp_valid = 1; bus_resp_rdata = 32'h0;
        dmem_en = 1; dmem_wen = 0; dmem_size = 3'd2; dmem_addr = 32'h508;
        #1;
        chk("b2b_done1_wait", 32'(dmem_wait), 32'd0);
        @(negedge clk);
        bus_resp_valid = 0; dmem_en = 0; bus_req_ready = 1;
        #1;
        chk("b2b_req2_valid", 32'(bus_req_valid), 32'd1);
        chk("b2b_req2_addr", bus_req_addr, 32'h508);
        chk("b2b_req2_strb", 32'(bus_req_strb), 32'd0);
        @(negedge clk);
        bus_req_ready = 0;
        @(negedge clk);
        bus_resp_valid = 1; bus_resp_rdata = 32'hAABBCCDD;
        #1;
        chk("b2b_done2_wait", 32'(dmem_wait), 32'd0);
        chk("b2b_done2_rdata", dmem_rdata, 32'hAABBCCDD);

        // Back-to-back out of a FAULT cycle
        cur = 101;
        @(negedge clk);
        idle_inputs();
        dmem_en = 1; dmem_wen = 0; dmem_size = 3'd2; dmem_addr = 32'h002;
        @(negedge clk);
        dmem_en = 1; dmem_wen = 1; dmem_size = 3'd0; dmem_addr = 32'h003;
        #1;
        chk("bf_fault_bad", 32'(dmem_badmem_e), 32'd1);
        chk("bf_fault_wait", 32'(dmem_wait), 32'd0);
        @(negedge clk);
        dmem_en = 0; bus_req_ready = 1; dmem_wdata_delayed = 32'h77777777;
        #1;
        chk("bf_req_valid", 32'(bus_req_valid), 32'd1);
        chk("bf_req_strb", 32'(bus_req_strb), 32'b1000);
        @(negedge clk);
        bus_req_ready = 0;
        @(negedge clk);
        bus_resp_valid = 1;
        #1;
        chk("bf_done_wait", 32'(dmem_wait), 32'd0);

        // Timeout on the TIMEOUT_CYCLES=4 instance with a silent bus
        cur = 102;
        pulse_reset();
        dmem_en = 1; dmem_wen = 0; dmem_size = 3'd2; dmem_addr = 32'h600;
        waits = 0; done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            dmem_en = 0;
            #1;
            if (!to_dmem_wait) begin
                done = 1;
                chk("to_badmem", 32'(to_dmem_badmem_e), 32'd1);
                chk("to_valid", 32'(to_bus_req_valid), 32'd0);
            end else begin
                waits++;
            end
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL v%0d to_completion: no completion within 10 cycles", cur);
        end
        chk("to_wait_cycles", 32'(waits), 32'd3);
        @(negedge clk);
        bus_resp_valid = 1; bus_resp_err = 1; bus_resp_rdata = 32'hFFFFFFFF;
        #1;
        chk("stray_badmem", 32'(to_dmem_badmem_e), 32'd0);
        chk("stray_wait", 32'(to_dmem_wait), 32'd0);
        chk("stray_rdata", to_dmem_rdata, 32'd0);

        // Reset asserted asynchronously while waiting in RESP
        cur = 103;
        pulse_reset();
        dmem_en = 1; dmem_wen = 1; dmem_size = 3'd2; dmem_addr = 32'h100;
        @(negedge clk);
        dmem_en = 0; bus_req_ready = 1; dmem_wdata_delayed = 32'h12121212;
        @(negedge clk);
        bus_req_ready = 0;
        #1;
        chk("mid_wait_before", 32'(dmem_wait), 32'd1);
        #2;
        reset = 1;
        #1;
        chk("mid_rst_wait", 32'(dmem_wait), 32'd0);
        chk("mid_rst_valid", 32'(bus_req_valid), 32'd0);
        chk("mid_rst_badmem", 32'(dmem_badmem_e), 32'd0);
        @(negedge clk);
        reset = 0;
        bus_resp_valid = 1; bus_resp_rdata = 32'h5A5A5A5A;
        #1;
        chk("post_rst_wait", 32'(dmem_wait), 32'd0);
        chk("post_rst_rdata", dmem_rdata, 32'd0);
        @(negedge clk);
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
